// File: rtl/pb_classifier_multi.sv
// N-channel push-button front end: per channel a 2-FF synchroniser, press/release
// debounce, and a SHORT/LONG press classifier with registered event pulses.
module pb_classifier_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_P      = 300,
  parameter int LONG_T          = 5000,
  parameter int LONG_ON_RELEASE = 0,
  parameter int CNT_W           = $clog2(LONG_T + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] short_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] held
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DB    = 3'd1;
  localparam logic [2:0] ST_PRESS = 3'd2;
  localparam logic [2:0] ST_LONG  = 3'd3;
  localparam logic [2:0] ST_REL   = 3'd4;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_P - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic             LONG_AT_REL = (LONG_ON_RELEASE != 0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       sync;
    logic             s;
    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] rcnt;
    logic             islong;
    logic             short_n;
    logic             long_n;
    logic             short_r;
    logic             long_r;
    logic             held_r;

    assign s = sync[1];

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
      state_n = state;
      short_n = 1'b0;
      long_n  = 1'b0;
      case (state)
        ST_IDLE:  if (s) state_n = ST_DB;
        ST_DB: begin
          if (!s)                  state_n = ST_IDLE;
          else if (pcnt == DB_LAST) state_n = ST_PRESS;
        end
        ST_PRESS: begin
          if (!s) state_n = ST_REL;
          else if (pcnt == LONG_LAST) begin
            state_n = ST_LONG;
            long_n  = !LONG_AT_REL;
          end
        end
        ST_LONG:  if (!s) state_n = ST_REL;
        ST_REL: begin
          if (s) state_n = islong ? ST_LONG : ST_PRESS;
          else if (rcnt == DB_LAST) begin
            state_n = ST_IDLE;
            short_n = !islong;
            long_n  = islong && LONG_AT_REL;
          end
        end
        default:  state_n = ST_IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync    <= '0;
        state   <= ST_IDLE;
        pcnt    <= '0;
        rcnt    <= '0;
        islong  <= 1'b0;
        short_r <= 1'b0;
        long_r  <= 1'b0;
        held_r  <= 1'b0;
      end else begin
        sync    <= {sync[0], pb[i]};
        state   <= state_n;
        short_r <= short_n;
        long_r  <= long_n;
        held_r  <= (state_n == ST_PRESS) || (state_n == ST_LONG) || (state_n == ST_REL);
        case (state)
          ST_IDLE: pcnt <= '0;
          ST_DB: begin
            if (s) begin
              if (pcnt == DB_LAST)       pcnt <= '0;
              else if (pcnt != CNT_MAX)  pcnt <= pcnt + CNT_ONE;
            end
          end
          ST_PRESS: begin
            if (!s) begin
              rcnt   <= '0;
              islong <= 1'b0;
            end else if (pcnt != LONG_LAST && pcnt != CNT_MAX) begin
              pcnt <= pcnt + CNT_ONE;
            end
          end
          ST_LONG: begin
            if (!s) begin
              rcnt   <= '0;
              islong <= 1'b1;
            end
          end
          // pcnt is left alone here so a release glitch resumes the hold timing
          ST_REL: if (!s && rcnt != CNT_MAX) rcnt <= rcnt + CNT_ONE;
          default: pcnt <= '0;
        endcase
      end
    end

    assign short_p[i] = short_r;
    assign long_p[i]  = long_r;
    assign held[i]    = held_r;
  end

endmodule

// File: tb/tb_pb_classifier_multi.sv
// Directed bench for pb_classifier_multi: two instances (long at threshold and
// long at release) driven by the same buttons, checked against hand-derived cycles.
module tb_pb_classifier_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] pb  = 2'b00;
  logic [1:0] short_p0, long_p0, held0;
  logic [1:0] short_p1, long_p1, held1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  // Per-instance, per-channel observation records (cycle numbers relative to t0).
  int sc  [2][2];
  int st  [2][2];
  int lc  [2][2];
  int lt  [2][2];
  int hr  [2][2];
  int hrt [2][2];
  int hf  [2][2];
  int both_cnt = 0;
  logic [1:0] hprev [2];

  always #5 clk = ~clk;

  pb_classifier_multi #(.N_CH(2), .DEBOUNCE_P(4), .LONG_T(20), .LONG_ON_RELEASE(0)) u_dut0 (
    .clk(clk), .rst(rst), .pb(pb), .short_p(short_p0), .long_p(long_p0), .held(held0));

  pb_classifier_multi #(.N_CH(2), .DEBOUNCE_P(4), .LONG_T(20), .LONG_ON_RELEASE(1)) u_dut1 (
    .clk(clk), .rst(rst), .pb(pb), .short_p(short_p1), .long_p(long_p1), .held(held1));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        sc[d][c] = 0; st[d][c] = 0; lc[d][c] = 0; lt[d][c] = 0;
        hr[d][c] = 0; hrt[d][c] = 0; hf[d][c] = 0;
      end
    end
    hprev[0] = held0;
    hprev[1] = held1;
    t0 = cyc;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          logic s, l, h;
          s = (d == 0) ? short_p0[c] : short_p1[c];
          l = (d == 0) ? long_p0[c]  : long_p1[c];
          h = (d == 0) ? held0[c]    : held1[c];
          if (s) begin sc[d][c]++; st[d][c] = cyc - t0; end
          if (l) begin lc[d][c]++; lt[d][c] = cyc - t0; end
          if (s && l) both_cnt++;
          if (h && !hprev[d][c]) begin hr[d][c]++; hrt[d][c] = cyc - t0; end
          if (!h && hprev[d][c]) hf[d][c] = cyc - t0;
          hprev[d][c] = h;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) hprev[i] = 2'b00;

    // Reset state
    #12;
    check("rst_short0", int'(short_p0), 0);
    check("rst_long1",  int'(long_p1),  0);
    check("rst_held",   int'({held1, held0}), 0);
    rst = 1'b1;
    step(3);

    // 1: 3-cycle glitch never reaches PRESS
    clear();
    pb = 2'b01; step(3);
    pb = 2'b00; step(20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t1_short_d%0d", d), sc[d][0], 0);
      check($sformatf("t1_long_d%0d",  d), lc[d][0], 0);
      check($sformatf("t1_held_d%0d",  d), hr[d][0], 0);
    end

    // 2: short press; held rises at edge 7, short_p at edge 17
    clear();
    pb = 2'b01; step(10);
    pb = 2'b00; step(20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t2_held_rise_d%0d", d), hrt[d][0], 7);
      check($sformatf("t2_held_fall_d%0d", d), hf[d][0],  17);
      check($sformatf("t2_short_cnt_d%0d", d), sc[d][0],  1);
      check($sformatf("t2_short_at_d%0d",  d), st[d][0],  17);
      check($sformatf("t2_long_cnt_d%0d",  d), lc[d][0],  0);
    end

    // 3: long press; threshold variant at edge 27, release variant at edge 47
    clear();
    pb = 2'b01; step(40);
    pb = 2'b00; step(20);
    check("t3_long_cnt_d0", lc[0][0], 1);
    check("t3_long_at_d0",  lt[0][0], 27);
    check("t3_long_cnt_d1", lc[1][0], 1);
    check("t3_long_at_d1",  lt[1][0], 47);
    check("t3_short_d0",    sc[0][0], 0);
    check("t3_short_d1",    sc[1][0], 0);
    check("t3_held_fall",   hf[0][0], 47);

    // 4: 2-cycle low glitch on ch1; three REL cycles do not count toward LONG_T
    clear();
    pb = 2'b10; step(14);
    pb = 2'b00; step(2);
    pb = 2'b10; step(24);
    pb = 2'b00; step(20);
    check("t4_long_at_d0",  lt[0][1], 30);
    check("t4_long_cnt_d0", lc[0][1], 1);
    check("t4_long_at_d1",  lt[1][1], 47);
    check("t4_short_d0",    sc[0][1], 0);
    check("t4_short_d1",    sc[1][1], 0);
    check("t4_held_rises",  hr[0][1], 1);

    // 5: simultaneous presses, short on ch0 and long on ch1
    clear();
    pb = 2'b11; step(10);
    pb = 2'b10; step(30);
    pb = 2'b00; step(20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t5_short0_d%0d", d), sc[d][0], 1);
      check($sformatf("t5_long0_d%0d",  d), lc[d][0], 0);
      check($sformatf("t5_short1_d%0d", d), sc[d][1], 0);
      check($sformatf("t5_long1_d%0d",  d), lc[d][1], 1);
    end
    check("t5_short0_at", st[0][0], 17);
    check("t5_long1_at0", lt[0][1], 27);
    check("t5_long1_at1", lt[1][1], 47);

    // 6: async reset while channel 0 is in LONG discards the press
    clear();
    pb = 2'b01; step(30);
    check("t6_held_before", int'(held1[0]), 1);
    rst = 1'b0;
    #1;
    check("t6_held_async",  int'({held1, held0}), 0);
    check("t6_pulse_async", int'({long_p1, long_p0, short_p1, short_p0}), 0);
    pb = 2'b00;
    #2;
    rst = 1'b1;
    clear();
    step(20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t6_short_d%0d", d), sc[d][0], 0);
      check($sformatf("t6_long_d%0d",  d), lc[d][0], 0);
      check($sformatf("t6_held_d%0d",  d), hr[d][0], 0);
    end

    check("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
